// File: rtl/pb_ctrl_pkg.sv
// Shared types and default timing constants for the push-button mode controller.
package pb_ctrl_pkg;

  typedef enum logic [1:0] {
    OFF     = 2'b00,
    STANDBY = 2'b01,
    RIDE    = 2'b10
  } mode_t;

  localparam logic [15:0] PB_DB_CYC_DEF   = 16'd50000;
  localparam logic [23:0] PB_LONG_CYC_DEF = 24'd5000000;

endpackage

// File: rtl/pb_mode_ctrl_if.sv
// Push-button / mode signal bundle between the board-level logic and pb_mode_ctrl.
interface pb_mode_ctrl_if;
  import pb_ctrl_pkg::*;

  logic  PB;
  logic  fault;
  logic  short_pulse;
  logic  long_pulse;
  mode_t mode;
  logic  pwr_up;
  logic  en_steer;

  modport master (
    output PB, fault,
    input  short_pulse, long_pulse, mode, pwr_up, en_steer
  );

  modport slave (
    input  PB, fault,
    output short_pulse, long_pulse, mode, pwr_up, en_steer
  );

endinterface

// File: rtl/pb_sync_db.sv
// 3-flop synchronizer for the raw active-low button followed by a stable-count debouncer.
module pb_sync_db
  import pb_ctrl_pkg::*;
#(
  parameter logic [15:0] DB_CYC = PB_DB_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic PB,
  output logic pb_db
);

  localparam int unsigned CW = $clog2(int'(DB_CYC));
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYC - 16'd1);

  logic [2:0]    sync_q;
  logic [CW-1:0] cnt_db;
  logic          synced;

  assign synced = sync_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[1:0], PB};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pb_db  <= 1'b1;
      cnt_db <= '0;
    end else if (synced == pb_db) begin
      cnt_db <= '0;
    end else if (cnt_db == CNT_LAST) begin
      pb_db  <= synced;
      cnt_db <= '0;
    end else begin
      cnt_db <= cnt_db + 1'b1;
    end
  end

endmodule

// File: rtl/pb_mode_ctrl.sv
// Push-button mode controller: short/long press classification driving OFF/STANDBY/RIDE.
// Long-press detection is built only when PB_LONG_PRESS_EN is defined.
module pb_mode_ctrl
  import pb_ctrl_pkg::*;
#(
  parameter logic [15:0] DB_CYC   = PB_DB_CYC_DEF,
  parameter logic [23:0] LONG_CYC = PB_LONG_CYC_DEF
) (
  input logic           clk,
  input logic           rst_n,
  pb_mode_ctrl_if.slave bus
);

  if (DB_CYC < 16'd2 || LONG_CYC < 24'd2) begin : g_bad_cfg
    $error("pb_mode_ctrl: DB_CYC and LONG_CYC must both be at least 2");
  end

  localparam int unsigned ST_LIM = int'(DB_CYC) + 4;
  localparam int unsigned SW = $clog2(ST_LIM + 1);
  localparam logic [SW-1:0] ST_LAST = SW'(ST_LIM);

  logic          pb_db, pb_db_q, pb_fall, pb_rise;
  logic          armed, primed, short_ok, long_hit;
  logic          short_q, long_q, pwr_up_q, en_steer_q;
  logic [SW-1:0] st_cnt;
  mode_t         mode_q, mode_nxt;

  pb_sync_db #(.DB_CYC(DB_CYC)) u_sync_db (
    .clk   (clk),
    .rst_n (rst_n),
    .PB    (bus.PB),
    .pb_db (pb_db)
  );

  assign pb_fall = pb_db_q & ~pb_db;
  assign pb_rise = ~pb_db_q & pb_db;
  assign primed  = (st_cnt == ST_LAST);

  // A fall that arrives before the sync chain and debouncer have settled after
  // reset belongs to a press already in progress, so it is never armed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pb_db_q <= 1'b1;
      st_cnt  <= '0;
      armed   <= 1'b0;
    end else begin
      pb_db_q <= pb_db;
      if (pb_db && !primed) st_cnt <= st_cnt + 1'b1;
      if (pb_fall)          armed <= primed & ~bus.fault;
      else if (bus.fault)   armed <= 1'b0;
    end
  end

`ifdef PB_LONG_PRESS_EN
  localparam int unsigned HW = $clog2(int'(LONG_CYC) + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYC);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYC - 24'd1);

  logic [HW-1:0] hold;
  logic          long_step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold        <= '0;
      long_step_q <= 1'b0;
    end else begin
      long_step_q <= ~pb_db && (hold == HOLD_PRE);
      if (pb_db)                 hold <= '0;
      else if (hold != HOLD_MAX) hold <= hold + 1'b1;
    end
  end

  assign short_ok = (hold != HOLD_MAX);
  assign long_hit = long_step_q;
`else
  assign short_ok = 1'b1;
  assign long_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      short_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      short_q <= pb_rise & armed & short_ok & ~bus.fault;
      long_q  <= long_hit & armed & ~bus.fault;
    end
  end

  always_comb begin
    mode_nxt = mode_q;
    if (bus.fault) begin
      mode_nxt = OFF;
    end else begin
      case (mode_q)
        OFF:     if (short_q) mode_nxt = STANDBY;
        STANDBY: if (short_q) mode_nxt = RIDE; else if (long_q) mode_nxt = OFF;
`ifdef PB_LONG_PRESS_EN
        RIDE:    if (short_q) mode_nxt = STANDBY; else if (long_q) mode_nxt = OFF;
`else
        RIDE:    if (short_q) mode_nxt = OFF;
`endif
        default: mode_nxt = OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= OFF;
      pwr_up_q   <= 1'b0;
      en_steer_q <= 1'b0;
    end else begin
      mode_q     <= mode_nxt;
      pwr_up_q   <= (mode_nxt != OFF);
      en_steer_q <= (mode_nxt == RIDE);
    end
  end

  assign bus.short_pulse = short_q;
  assign bus.long_pulse  = long_q;
  assign bus.mode        = mode_q;
  assign bus.pwr_up      = pwr_up_q;
  assign bus.en_steer    = en_steer_q;

endmodule

// File: tb/tb_pb_mode_ctrl.sv
// Directed bench for pb_mode_ctrl with a pulse scoreboard keyed on expected cycle.
module tb_pb_mode_ctrl;
  import pb_ctrl_pkg::*;

  localparam logic [15:0] DB   = 16'd4;
  localparam logic [23:0] LONG = 24'd20;
  localparam int unsigned SHORT_LAT = 3 + 4 + 1;
  localparam int unsigned LONG_LAT  = 3 + 4 + 20 + 1;

  typedef struct {
    bit          is_long;
    int unsigned at;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;
  ev_t         sb[$];
  ev_t         ev;
  int unsigned c;

  pb_mode_ctrl_if bus ();

  pb_mode_ctrl #(.DB_CYC(DB), .LONG_CYC(LONG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_mode(input string tag, input mode_t exp);
    check({tag, "_mode"}, 32'(bus.mode), 32'(exp));
    check({tag, "_pwr_up"}, 32'(bus.pwr_up), 32'(exp != OFF));
    check({tag, "_en_steer"}, 32'(bus.en_steer), 32'(exp == RIDE));
  endtask

  // Every observed pulse must match the oldest expected one by kind and cycle.
  always @(negedge clk) begin
    if (rst_n && (bus.short_pulse || bus.long_pulse)) begin
      check("pulse_excl", 32'(bus.short_pulse & bus.long_pulse), 32'd0);
      if (sb.size() == 0) begin
        check("pulse_unexpected", {30'd0, bus.long_pulse, bus.short_pulse}, 32'd0);
      end else begin
        ev = sb.pop_front();
        check("pulse_kind_long", 32'(bus.long_pulse), 32'(ev.is_long));
        check("pulse_cycle", cyc, ev.at);
      end
    end
  end

  task automatic press(input int unsigned low_len, input bit exp_short, input bit exp_long,
                       input mode_t exp_mode, input string tag);
    @(negedge clk);
    bus.PB = 1'b0;
    if (exp_long) sb.push_back('{1'b1, cyc + LONG_LAT});
    repeat (low_len) @(negedge clk);
    bus.PB = 1'b1;
    if (exp_short) sb.push_back('{1'b0, cyc + SHORT_LAT});
    repeat (20) @(negedge clk);
    check_mode(tag, exp_mode);
  endtask

  initial begin
    logic [19:0] glitch_pat;
    bus.PB    = 1'b1;
    bus.fault = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_short", 32'(bus.short_pulse), 32'd0);
    check("rst_long", 32'(bus.long_pulse), 32'd0);
    check_mode("rst", OFF);
    rst_n = 1'b1;

    repeat (50) @(negedge clk);
    check_mode("idle50", OFF);

    // First press: mode must change exactly 9 clocks after the release.
    @(negedge clk);
    bus.PB = 1'b0;
    repeat (10) @(negedge clk);
    bus.PB = 1'b1;
    c = cyc;
    sb.push_back('{1'b0, c + SHORT_LAT});
    repeat (8) @(negedge clk);
    check("t8_mode", 32'(bus.mode), 32'(OFF));
    @(negedge clk);
    check_mode("t9", STANDBY);
    repeat (20) @(negedge clk);

    press(10, 1'b1, 1'b0, RIDE, "press2");

`ifdef PB_LONG_PRESS_EN
    press(40, 1'b0, 1'b1, OFF, "long40");
    press(10, 1'b1, 1'b0, STANDBY, "relong_a");
    press(10, 1'b1, 1'b0, RIDE, "relong_b");
`else
    press(40, 1'b1, 1'b0, OFF, "cyc40_a");
    press(40, 1'b1, 1'b0, STANDBY, "cyc40_b");
    press(40, 1'b1, 1'b0, RIDE, "cyc40_c");
`endif

    glitch_pat = 20'b000_111_000_111_00_111111;
    for (int i = 19; i >= 0; i--) begin
      @(negedge clk);
      bus.PB = glitch_pat[i];
      check("glitch_pb_db", 32'(dut.u_sync_db.pb_db), 32'd1);
    end
    repeat (10) @(negedge clk);
    check("glitch_pb_db_end", 32'(dut.u_sync_db.pb_db), 32'd1);
    check_mode("glitch", RIDE);

    @(negedge clk);
    bus.PB = 1'b0;
    repeat (8) @(negedge clk);
    bus.fault = 1'b1;
    @(negedge clk);
    bus.fault = 1'b0;
    check_mode("fault_next", OFF);
    @(negedge clk);
    bus.PB = 1'b1;
    repeat (20) @(negedge clk);
    check_mode("fault_release", OFF);
    press(10, 1'b1, 1'b0, STANDBY, "after_fault");

    @(negedge clk);
    bus.PB = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_short", 32'(bus.short_pulse), 32'd0);
    check_mode("midrst", OFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    bus.PB = 1'b1;
    repeat (20) @(negedge clk);
    check_mode("midrst_release", OFF);

    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
